// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default geometry and FSM state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial input plus CPU-side read/error bundle of the oversampling UART receiver.
interface uart_rx_os_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
);
  logic                 rx;
  logic                 rd_en;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [CNT_W-1:0]     fifo_count;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx, rd_en, clr_err,
    input  rd_data, rd_valid, fifo_count, frame_err, overrun, busy
  );

  modport slave (
    input  rx, rd_en, clr_err,
    output rd_data, rd_valid, fifo_count, frame_err, overrun, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through circular FIFO; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {CNT_W{1'b0}};
      rd_ptr_q <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver on a 16x oversample clock: synchroniser, mid-bit sampling FSM,
// receive FIFO and sticky framing/overrun flags.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  uart_rx_os_if.slave bus
);
  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TC_W-1:0] TC_ZERO = {TC_W{1'b0}};
  localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_ZERO = {BI_W{1'b0}};
  localparam logic [BI_W-1:0] BI_ONE  = BI_W'(1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  state_e               state_q, state_d;
  logic [TC_W-1:0]      tc_q, tc_d;
  logic [BI_W-1:0]      bi_q, bi_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic rxs_s;
  logic push_s;
  logic fe_set_s;
  logic drop_s;
  logic busy_s;
  logic fifo_full_s;
  logic fifo_empty_s;

  assign sync_d = {sync_q[0], bus.rx};
  assign rxs_s  = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      tc_q        <= TC_ZERO;
      bi_q        <= BI_ZERO;
      shreg_q     <= {DATA_BITS{1'b0}};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tc_q        <= tc_d;
      bi_q        <= bi_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bi_d    = bi_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        tc_d = TC_ZERO;
        if (!rxs_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Half a bit into the start bit: a line that is high again was only a glitch.
      ST_START: begin
        if (tc_q == TC_HALF) begin
          tc_d = TC_ZERO;
          bi_d = BI_ZERO;
          if (!rxs_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tc_d = tc_q + TC_ONE;
        end
      end
      ST_DATA: begin
        if (tc_q == TC_LAST) begin
          tc_d          = TC_ZERO;
          shreg_d[bi_q] = rxs_s;
          bi_d          = bi_q + BI_ONE;
          if (bi_q == BI_LAST) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          tc_d = tc_q + TC_ONE;
        end
      end
      ST_STOP: begin
        if (tc_q == TC_LAST) begin
          tc_d = TC_ZERO;
          if (rxs_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          tc_d = tc_q + TC_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        tc_d = TC_ZERO;
        if (rxs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tc_d    = TC_ZERO;
        bi_d    = BI_ZERO;
      end
    endcase
  end

  always_comb begin
    push_s   = 1'b0;
    fe_set_s = 1'b0;
    if ((state_q == ST_STOP) && (tc_q == TC_LAST)) begin
      push_s   = rxs_s;
      fe_set_s = !rxs_s;
    end else begin
      push_s   = 1'b0;
      fe_set_s = 1'b0;
    end
    busy_s = (state_q != ST_IDLE);
  end

  // A full FIFO only drops the byte if no pop frees a slot in the same cycle.
  assign drop_s = push_s && fifo_full_s && !bus.rd_en;

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (fe_set_s) begin
      frame_err_d = 1'b1;
    end else if (bus.clr_err) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (shreg_q),
    .pop     (bus.rd_en),
    .rd_data (bus.rd_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (bus.fifo_count)
  );

  assign bus.rd_valid  = !fifo_empty_s;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_s;
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver clocked directly by the divided clk_uart output of the clock generator, which is treated as a 16x-oversample clock.
- Synchronises the serial rx pin and frames 8N1 characters by mid-bit sampling.
- Buffers received bytes in a small first-word-fall-through FIFO for the CPU-side UART register logic.
- Flags framing and overrun errors as sticky bits.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit; even, >=4.
- DATA_BITS, 8, data bits per frame, LSB first.
- FIFO_DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 3, FIFO count width = log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  oversample clock (clk_uart).
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line; idle high.
- rd_en  input  1  pop head entry when rd_valid=1.
- clr_err  input  1  clears frame_err and overrun.
- rd_data  output  DATA_BITS  FIFO head entry; valid when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  CNT_W  number of occupied entries, 0..FIFO_DEPTH.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
Reset (async, active-high):
- Both synchroniser flops =1; FSM=IDLE; counters=0; FIFO empty.
- Outputs: rd_data=0, rd_valid=0, fifo_count=0, frame_err=0, overrun=0, busy=0.

Input path:
- rx passes a 2-flop synchroniser; only the synchronised value rxs is used.

FSM (IDLE, START, DATA, STOP, WAIT_IDLE), with tick counter tc and bit index bi:
- IDLE: rxs==0 -> START, tc=0.
- START: when tc==OVERSAMPLE/2-1, sample rxs.
  - rxs==0: go to DATA, tc=0, bi=0.
  - rxs==1 (glitch): return to IDLE; nothing is pushed.
- DATA: when tc==OVERSAMPLE-1, shift rxs into shreg at bit bi (LSB first) and reset tc.
  - After bit DATA_BITS-1: go to STOP.
- STOP: when tc==OVERSAMPLE-1, sample rxs.
  - rxs==1: push shreg; go to IDLE.
  - rxs==0: frame_err<=1; discard the byte; go to WAIT_IDLE.
- WAIT_IDLE: rxs==1 -> IDLE. Covers a break condition and prevents false restarts.

Latency:
- The byte is visible on rd_data, with rd_valid=1, on the cycle after the stop-sample edge.

FIFO (FWFT, circular, rd/wr pointers of CNT_W bits with wrap-around):
- rd_data is always mem[rd_ptr]; it is held at its last value when empty.
- rd_en while empty is ignored.
- Push while full: byte dropped, overrun<=1, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Both succeed and fifo_count is unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overrun.
  - When empty, only the push occurs (pop ignored).

Error flags:
- clr_err clears frame_err and overrun on the next edge.
- A set event in the same cycle as clr_err wins, so the flag stays 1.

Other rules:
- rst asserted mid-frame aborts the frame; no partial byte is ever pushed.
- busy = (state != IDLE).

Decomposition:
- Package uart_pkg: FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4), OVERSAMPLE/DATA_BITS defaults.
- Sub-module sync_fifo: parameterised FWFT FIFO (width, depth) exposing full/empty/count. Reusable by the future uart_tx.
- Top module uart_rx_os contains the synchroniser, FSM, shift register and error flags.

Test Plan:
- Frame 0x55 (start 0, bits LSB-first, stop 1, 16 clk/bit) -> rd_valid=1 and rd_data=0x55 one cycle after the stop sample; fifo_count=1; frame_err=0.
- rx low for 4 clk then high -> FSM returns to IDLE; rd_valid stays 0; busy drops within 8 clk.
- Frame 0xA3 with stop bit 0, then rx held low 40 clk -> frame_err=1; fifo_count=0; busy=1 until rx returns high; clr_err pulse -> frame_err=0.
- Five frames 0x01..0x05 with no reads -> fifo_count=4, overrun=1, rd_data=0x01; four pops return 0x01,0x02,0x03,0x04; rd_valid=0.
- FIFO full (4 entries), rd_en asserted on the push cycle of a fifth byte 0x99 -> overrun stays 0; fifo_count stays 4; the last entry read back is 0x99.
- rst asserted at bit 3 of a frame, released, then clean 0x3C sent -> only 0x3C appears; all outputs were at reset values during rst.
